// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type/ADDI pipelined core: opcode and funct
// encodings, instruction field positions, ALU operation enum and the
// decoded-instruction record produced in the D stage.
package rtype_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int FN_LSB = 0;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [4:0] dst;      // full 5-bit field; the core keeps the low bits
    logic       use_rs;
    logic       use_rt;   // only R-type reads rt; for ADDI rt is the target
    logic       use_imm;
    logic       wen;
    logic       illegal;
  } dec_t;

  // Illegal encodings decode to a no-write, no-read instruction so they never
  // cause a hazard and simply flag at retire.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rt, input logic [4:0] rd);
    dec_t d;
    d.alu_op  = ALU_NONE;
    d.dst     = '0;
    d.use_rs  = 1'b0;
    d.use_rt  = 1'b0;
    d.use_imm = 1'b0;
    d.wen     = 1'b0;
    d.illegal = 1'b1;
    if (op == OP_RTYPE) begin
      d.dst     = rd;
      d.use_rs  = 1'b1;
      d.use_rt  = 1'b1;
      d.wen     = 1'b1;
      d.illegal = 1'b0;
      case (fn)
        FN_ADD:  d.alu_op = ALU_ADD;
        FN_SUB:  d.alu_op = ALU_SUB;
        FN_AND:  d.alu_op = ALU_AND;
        FN_OR:   d.alu_op = ALU_OR;
        FN_SLT:  d.alu_op = ALU_SLT;
        default: begin
          d.dst     = '0;
          d.use_rs  = 1'b0;
          d.use_rt  = 1'b0;
          d.wen     = 1'b0;
          d.illegal = 1'b1;
        end
      endcase
    end else if (op == OP_ADDI) begin
      d.alu_op  = ALU_ADD;
      d.dst     = rt;
      d.use_rs  = 1'b1;
      d.use_imm = 1'b1;
      d.wen     = 1'b1;
      d.illegal = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational ALU for the E stage. Arithmetic wraps modulo 2^DATA_W;
// SLT is a signed compare producing a zero-extended 0/1.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   y
);

  // Operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rtype_pipe_core.sv
// Three-stage (F/D/E) pipelined core for R-type and ADDI instructions.
// Instruction ROM is external and read combinationally at imem_addr.
// Every register write is mirrored on wb_*; illegal pulses at retire.
// Build option RTCORE_FORWARD_EN: forward the E result into D instead of
// inserting a one-cycle bubble on a distance-1 read-after-write hazard.
module rtype_pipe_core
  import rtype_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic [PC_W-3:0]            imem_addr,
  input  logic [31:0]                imem_data,
  output logic [PC_W-1:0]            pc,
  output logic                       wb_valid,
  output logic [$clog2(REG_N)-1:0]   wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       illegal
);

  localparam int RA_W = $clog2(REG_N);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:1]        vld_pipe_q, vld_pipe_d;   // [1] IF/ID, [2] ID/EX
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  alu_op_e           ex_op_q, ex_op_d;
  logic [RA_W-1:0]   ex_dst_q, ex_dst_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_ill_q, ex_ill_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];
  logic              wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  dec_t              dec;
  logic [RA_W-1:0]   rs_a, rt_a, dst_a;
  logic [DATA_W-1:0] rs_v, rt_v, imm_ext, alu_y;
  logic              hz_rs, hz_rt, stall;

  rtype_alu #(.DATA_W(DATA_W)) u_alu (
    .op (ex_op_q),
    .a  (ex_a_q),
    .b  (ex_b_q),
    .y  (alu_y)
  );

  // D stage: decode, register read (r0 reads 0), hazard detect and bypass
  always_comb begin
    dec     = decode(ifid_instr_q[OP_LSB +: 6], ifid_instr_q[FN_LSB +: 6],
                     ifid_instr_q[RT_LSB +: 5], ifid_instr_q[RD_LSB +: 5]);
    rs_a    = ifid_instr_q[RS_LSB +: RA_W];
    rt_a    = ifid_instr_q[RT_LSB +: RA_W];
    dst_a   = dec.dst[RA_W-1:0];
    imm_ext = DATA_W'($signed(ifid_instr_q[15:0]));
    // ex_wen_q already excludes r0, so a write to r0 is never a hazard
    hz_rs   = vld_pipe_q[1] & vld_pipe_q[2] & ex_wen_q & dec.use_rs & (rs_a == ex_dst_q);
    hz_rt   = vld_pipe_q[1] & vld_pipe_q[2] & ex_wen_q & dec.use_rt & (rt_a == ex_dst_q);
    rs_v    = (rs_a == '0) ? '0 : rf_q[rs_a];
    rt_v    = (rt_a == '0) ? '0 : rf_q[rt_a];
`ifdef RTCORE_FORWARD_EN
    stall   = 1'b0;
    if (hz_rs) rs_v = alu_y;
    if (hz_rt) rt_v = alu_y;
`else
    stall   = hz_rs | hz_rt;
`endif
  end

  // Next state for all stages; run=0 freezes everything and idles wb/illegal
  always_comb begin
    pc_d         = pc_q;
    vld_pipe_d   = vld_pipe_q;
    ifid_instr_d = ifid_instr_q;
    ex_op_d      = ex_op_q;
    ex_dst_d     = ex_dst_q;
    ex_wen_d     = ex_wen_q;
    ex_ill_d     = ex_ill_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    rf_d         = rf_q;
    wb_valid_d   = 1'b0;
    illegal_d    = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    if (run) begin
      // E: retire
      if (vld_pipe_q[2] && ex_wen_q) rf_d[ex_dst_q] = alu_y;
      wb_valid_d = vld_pipe_q[2] & ex_wen_q;
      illegal_d  = vld_pipe_q[2] & ex_ill_q;
      if (vld_pipe_q[2]) begin
        wb_addr_d = ex_dst_q;
        wb_data_d = alu_y;
      end
      if (stall) begin
        // F and D hold; one bubble into E
        vld_pipe_d[2] = 1'b0;
        ex_wen_d      = 1'b0;
        ex_ill_d      = 1'b0;
      end else begin
        pc_d          = pc_q + PC_W'(4);
        ifid_instr_d  = imem_data;
        vld_pipe_d[1] = 1'b1;
        vld_pipe_d[2] = vld_pipe_q[1];
        ex_op_d       = dec.alu_op;
        ex_dst_d      = dst_a;
        ex_wen_d      = vld_pipe_q[1] & dec.wen & (dst_a != '0);
        ex_ill_d      = vld_pipe_q[1] & dec.illegal;
        ex_a_d        = rs_v;
        ex_b_d        = dec.use_imm ? imm_ext : rt_v;
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= '0;
      vld_pipe_q   <= '0;
      ifid_instr_q <= '0;
      ex_op_q      <= ALU_ADD;
      ex_dst_q     <= '0;
      ex_wen_q     <= 1'b0;
      ex_ill_q     <= 1'b0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      vld_pipe_q   <= vld_pipe_d;
      ifid_instr_q <= ifid_instr_d;
      ex_op_q      <= ex_op_d;
      ex_dst_q     <= ex_dst_d;
      ex_wen_q     <= ex_wen_d;
      ex_ill_q     <= ex_ill_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      rf_q         <= rf_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q[PC_W-1:2];
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rtype_pipe_core.sv
// Scoreboard bench for rtype_pipe_core: the stimulus pushes the hand-computed
// writeback/illegal sequence, a negedge monitor pops and compares on every
// wb_valid/illegal. Timing (pc hold, bubble, freeze, async reset) is checked
// directly by the stimulus against hand-derived cycle tables.
module tb_rtype_pipe_core;

`ifdef RTCORE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0020;  // ADD r0,r0,r0

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  logic [31:0] mem [256];
  logic        unused_addr_hi;

  typedef struct packed {
    logic        ill;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;

  always #5 clk = ~clk;

  assign imem_data      = mem[imem_addr[7:0]];
  assign unused_addr_hi = ^imem_addr[29:8];

  rtype_pipe_core dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc        (pc),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.ill = 1'b0; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_ill();
    exp_t e;
    e.ill = 1'b1; e.a = '0; e.d = '0;
    sb.push_back(e);
  endtask

  // Program order of retired events; the r0 write at index 8 produces nothing
  task automatic push_prog();
    push_wb(5'd1,  32'h0000_0005);
    push_wb(5'd2,  32'hFFFF_FFFD);
    push_wb(5'd3,  32'h0000_0002);
    push_wb(5'd14, 32'h0000_0000);
    push_wb(5'd4,  32'hFFFF_FFF8);
    push_wb(5'd5,  32'h0000_0001);
    push_wb(5'd6,  32'h0000_0005);
    push_wb(5'd7,  32'hFFFF_FFFD);
    push_wb(5'd8,  32'h0000_0000);
    push_ill();
    push_wb(5'd9,  32'h0000_7FFF);
    push_wb(5'd10, 32'h0000_8000);
    push_wb(5'd11, 32'hFFFF_FFFB);
    push_wb(5'd12, 32'h0000_0000);
    push_wb(5'd13, 32'hFFFF_FFFA);
    push_wb(5'd15, 32'hFFFF_8000);
    push_wb(5'd15, 32'h0000_0007);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every presented writeback / illegal pulse
  always @(negedge clk) begin
    if (rst) begin
      if (wb_valid && illegal) begin
        nchk++;
        $display("FAIL wb_and_illegal: both high, addr %0d data 0x%0h", wb_addr, wb_data);
      end else if (wb_valid || illegal) begin
        exp_t e;
        nchk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out: wb_valid %0b addr %0d data 0x%0h illegal %0b, nothing expected",
                   wb_valid, wb_addr, wb_data, illegal);
        end else begin
          e = sb.pop_front();
          if (e.ill == illegal && (e.ill || (wb_addr == e.a && wb_data == e.d))) npass++;
          else $display("FAIL scoreboard: got wb %0b r%0d=0x%0h ill %0b expected ill %0b r%0d=0x%0h",
                        wb_valid, wb_addr, wb_data, illegal, e.ill, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc_tab[6];
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0]  = addi(5'd0, 5'd1, 16'd5);
    mem[1]  = addi(5'd0, 5'd2, 16'hFFFD);
    mem[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3]  = rtype(5'd13, 5'd0, 5'd14, 6'h20);
    mem[4]  = rtype(5'd2, 5'd1, 5'd4, 6'h22);
    mem[5]  = rtype(5'd2, 5'd1, 5'd5, 6'h2A);
    mem[6]  = rtype(5'd1, 5'd2, 5'd6, 6'h24);
    mem[7]  = rtype(5'd1, 5'd2, 5'd7, 6'h25);
    mem[8]  = rtype(5'd1, 5'd1, 5'd0, 6'h20);
    mem[9]  = rtype(5'd0, 5'd0, 5'd8, 6'h20);
    mem[10] = 32'h8C00_0000;
    mem[11] = addi(5'd0, 5'd9, 16'h7FFF);
    mem[12] = addi(5'd9, 5'd10, 16'd1);
    mem[13] = rtype(5'd0, 5'd1, 5'd11, 6'h22);
    mem[14] = rtype(5'd1, 5'd2, 5'd12, 6'h2A);
    mem[15] = rtype(5'd2, 5'd2, 5'd13, 6'h20);
    mem[16] = addi(5'd0, 5'd15, 16'h8000);
    mem[17] = addi(5'd0, 5'd15, 16'd7);

    if (FWD) pc_tab = '{0, 4, 8, 12, 16, 20};
    else     pc_tab = '{0, 4, 8, 12, 12, 16};

    // Reset held with run high
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
    end

    // Pass 1: full program with a freeze in the middle
    push_prog();
    rst = 1'b1;
    chk("p1_pc_c0", 64'(pc), 64'(pc_tab[0]));
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("p1_pc", 64'(pc), 64'(pc_tab[c]));
    end
    chk("p1_bubble_c5", 64'(wb_valid), FWD ? 64'd1 : 64'd0);
    for (int c = 6; c <= 8; c++) step();
    chk("p1_pc_c8", 64'(pc), FWD ? 64'd32 : 64'd28);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc", 64'(pc), FWD ? 64'd32 : 64'd28);
      chk("frz_wb_valid", 64'(wb_valid), 64'd0);
    end
    run = 1'b1;
    step();
    chk("unfrz_pc", 64'(pc), FWD ? 64'd36 : 64'd32);
    drain("p1_drain");

    // Pass 2: reset asserted while r1 writeback is on the bus
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    chk("p2_wb_valid_c3", 64'(wb_valid), 64'd1);
    chk("p2_wb_addr_c3", 64'(wb_addr), 64'd1);
    chk("p2_wb_data_c3", 64'(wb_data), 64'd5);
    #1 rst = 1'b0;
    #1;
    chk("async_pc", 64'(pc), 64'd0);
    chk("async_wb_valid", 64'(wb_valid), 64'd0);
    chk("async_wb_addr", 64'(wb_addr), 64'd0);
    chk("async_wb_data", 64'(wb_data), 64'd0);
    step();
    step();

    // Pass 3: restart from pc 0 with a freshly cleared register file
    push_prog();
    rst = 1'b1;
    chk("p3_pc_c0", 64'(pc), 64'd0);
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) chk("p3_pc_c1", 64'(pc), 64'd4);
      if (c == 2) chk("p3_pc_c2", 64'(pc), 64'd8);
    end
    chk("p3_pc_c25", 64'(pc), FWD ? 64'd100 : 64'd92);
    drain("p3_drain");
    for (int i = 0; i < 5; i++) step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
